// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM datapath: duty width, default PWM period,
// ramp controller state encoding and the command record.
package pwm_pkg;

  localparam int DUTY_W            = 32'sd8;
  localparam int PWM_PERIOD_CYCLES = 32'sd100000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  typedef struct packed {
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] step;
  } cmd_t;

  // Distance between two duty values, one bit wider so it can never wrap.
  function automatic logic [DUTY_W:0] abs_diff(input logic [DUTY_W-1:0] a,
                                               input logic [DUTY_W-1:0] b);
    logic [DUTY_W:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, b} - {1'b0, a};
    end
    return d;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running period counter. tick is high for one clk cycle at the end of
// every TICK_DIV-cycle period; shared with the PWM compare stage so both see
// the same period boundaries.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int TICK_DIV = pwm_pkg::PWM_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W    = (TICK_DIV > 32'sd1) ? $clog2(TICK_DIV) : 32'sd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  logic [CNT_W-1:0] count_r;

  assign tick = (count_r == CNT_LAST);

  // Period counter: 0..TICK_DIV-1, wrapping; never restarted by commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (tick) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty ramp controller feeding the PWM compare stage. Takes target/step
// commands over valid/ready, slews the duty toward the target once per PWM
// period and keeps one queued command so fades can be chained back to back.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int                     DUTY_W    = pwm_pkg::DUTY_W,
  parameter int                     TICK_DIV  = pwm_pkg::PWM_PERIOD_CYCLES,
  parameter logic [DUTY_W-1:0]      INIT_DUTY = {DUTY_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [DUTY_W-1:0] cmd_step,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_update,
  output logic              busy,
  output logic              done
);

  // Command records use the package width; DUTY_W is expected to match it.
  localparam logic [DUTY_W-1:0] STEP_ZERO = {DUTY_W{1'b0}};

  ramp_state_t       state_r, state_next_s;
  cmd_t              active_r, active_next_s;
  cmd_t              pend_r, pend_next_s;
  cmd_t              cmd_in_s;
  logic              pend_valid_r, pend_valid_next_s;
  logic [DUTY_W-1:0] duty_r, duty_next_s;
  logic              duty_update_r;
  logic              busy_r;
  logic              done_r, done_next_s;
  logic              tick_s;
  logic              accept_s;
  logic [DUTY_W:0]   diff_s;
  logic              finish_s;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // The queued slot is the only thing that can refuse a command.
  assign cmd_ready = ~pend_valid_r;
  assign accept_s  = cmd_valid & ~pend_valid_r;
  assign cmd_in_s  = {cmd_target, cmd_step};

  // A step of zero, or a remaining distance within one step, lands exactly.
  assign diff_s   = abs_diff(active_r.target, duty_r);
  assign finish_s = (active_r.step == STEP_ZERO) || (diff_s <= {1'b0, active_r.step});

  assign duty        = duty_r;
  assign duty_update = duty_update_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Next-state, next-duty and command slot management.
  always_comb begin
    state_next_s      = state_r;
    duty_next_s       = duty_r;
    active_next_s     = active_r;
    pend_next_s       = pend_r;
    pend_valid_next_s = pend_valid_r;
    done_next_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          active_next_s = cmd_in_s;
          state_next_s  = RAMP;
        end else begin
          state_next_s  = IDLE;
        end
      end

      RAMP: begin
        if (tick_s && finish_s) begin
          duty_next_s = active_r.target;
          done_next_s = 1'b1;
          if (pend_valid_r) begin
            // Chain straight into the queued fade; no idle gap.
            active_next_s     = pend_r;
            pend_valid_next_s = 1'b0;
          end else if (accept_s) begin
            // Command arriving on the completing tick skips the queue.
            active_next_s = cmd_in_s;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          if (tick_s) begin
            if (active_r.target > duty_r) begin
              duty_next_s = duty_r + active_r.step;
            end else begin
              duty_next_s = duty_r - active_r.step;
            end
          end else begin
            duty_next_s = duty_r;
          end
          if (accept_s) begin
            pend_next_s       = cmd_in_s;
            pend_valid_next_s = 1'b1;
          end else begin
            pend_valid_next_s = pend_valid_r;
          end
        end
      end

      default: begin
        state_next_s      = IDLE;
        pend_valid_next_s = 1'b0;
      end
    endcase
  end

  // Controller state and command slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      active_r     <= '{target: {DUTY_W{1'b0}}, step: {DUTY_W{1'b0}}};
      pend_r       <= '{target: {DUTY_W{1'b0}}, step: {DUTY_W{1'b0}}};
      pend_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      active_r     <= active_next_s;
      pend_r       <= pend_next_s;
      pend_valid_r <= pend_valid_next_s;
    end
  end

  // Registered outputs: duty and its change/status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r        <= INIT_DUTY;
      duty_update_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      duty_r        <= duty_next_s;
      duty_update_r <= (duty_next_s != duty_r);
      busy_r        <= (state_next_s == RAMP);
      done_r        <= done_next_s;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a 10-cycle tick period.
module tb_pwm_duty_ramp;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_target = 8'd0;
  logic [7:0] cmd_step = 8'd0;
  logic [7:0] duty;
  logic       duty_update;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass = 0;
  int cyc;
  int gap_cnt = 0;
  bit gap_win = 1'b0;
  int upd_val_q[$];
  int upd_cyc_q[$];
  int done_cyc_q[$];
  int exp_q[$];

  pwm_duty_ramp #(
    .DUTY_W    (8),
    .TICK_DIV  (TD),
    .INIT_DUTY (8'd0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .duty        (duty),
    .duty_update (duty_update),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; ticks land on multiples of TD.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record duty changes and done pulses with their cycle numbers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (duty_update) begin
        upd_val_q.push_back(int'(duty));
        upd_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (gap_win && !busy) gap_cnt++;
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    else return -1;
  endfunction

  task automatic check_q(input string tag, input int q[$], input int e[$]);
    check({tag, "_len"}, q.size(), e.size());
    for (int i = 0; i < e.size(); i++) check($sformatf("%s[%0d]", tag, i), q_at(q, i), e[i]);
  endtask

  task automatic clear_log();
    upd_val_q.delete();
    upd_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Offer a command starting at a negedge; returns at the negedge after transfer.
  task automatic send(input logic [7:0] t, input logic [7:0] s, input string tag);
    int guard;
    guard = 0;
    cmd_target = t;
    cmd_step   = s;
    cmd_valid  = 1'b1;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_upd", int'(duty_update), 0);
    rst_n = 1'b1;
    clear_log();

    // Ramp 0 -> 10 by 3
    send(8'd10, 8'd3, "a_send");
    check("a_busy_rise", int'(busy), 1);
    wait_until(9);
    check("a_before_tick", int'(duty), 0);
    wait_until(10);
    check("a_first_duty", int'(duty), 3);
    wait_until(40);
    check("a_done_pulse", int'(done), 1);
    check("a_busy_fall", int'(busy), 0);
    wait_until(41);
    exp_q = '{3, 6, 9, 10};        check_q("a_vals", upd_val_q, exp_q);
    exp_q = '{10, 20, 30, 40};     check_q("a_cycs", upd_cyc_q, exp_q);
    exp_q = '{40};                 check_q("a_done", done_cyc_q, exp_q);
    check("a_done_clear", int'(done), 0);
    clear_log();

    // Jump to 200, then jump to 50 with no intermediate values
    send(8'd200, 8'd0, "b_send1");
    wait_until(51);
    check("b_at_200", int'(duty), 200);
    clear_log();
    send(8'd50, 8'd0, "b_send2");
    wait_until(61);
    exp_q = '{50};                 check_q("b_vals", upd_val_q, exp_q);
    exp_q = '{60};                 check_q("b_cycs", upd_cyc_q, exp_q);
    exp_q = '{60};                 check_q("b_done", done_cyc_q, exp_q);
    check("b_busy", int'(busy), 0);
    clear_log();

    // Target equals current duty
    send(8'd50, 8'd5, "c_send");
    wait_until(71);
    check("c_upd_none", upd_val_q.size(), 0);
    exp_q = '{70};                 check_q("c_done", done_cyc_q, exp_q);
    check("c_duty", int'(duty), 50);
    clear_log();

    // Queued fades: 50->100 by 25, then 100->20 by 40, then jump to 5
    send(8'd100, 8'd25, "d_send1");
    wait_until(73);
    send(8'd20, 8'd40, "d_send2");
    check("d_ready_drop", int'(cmd_ready), 0);
    check("d_busy", int'(busy), 1);
    gap_win = 1'b1;
    send(8'd5, 8'd0, "d_send3");
    check("d_stall_cycle", cyc, 91);
    check("d_ready_refull", int'(cmd_ready), 0);
    wait_until(119);
    gap_win = 1'b0;
    wait_until(121);
    check("d_no_idle_gap", gap_cnt, 0);
    exp_q = '{75, 100, 60, 20, 5};       check_q("d_vals", upd_val_q, exp_q);
    exp_q = '{80, 90, 100, 110, 120};    check_q("d_cycs", upd_cyc_q, exp_q);
    exp_q = '{90, 110, 120};             check_q("d_done", done_cyc_q, exp_q);
    check("d_busy_end", int'(busy), 0);
    clear_log();

    // Reset mid-ramp at duty 37 with a queued command
    send(8'd101, 8'd32, "e_send1");
    wait_until(131);
    send(8'd200, 8'd1, "e_send2");
    wait_until(135);
    check("e_mid_duty", int'(duty), 37);
    check("e_mid_busy", int'(busy), 1);
    check("e_mid_ready", int'(cmd_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("e_async_duty", int'(duty), 0);
    check("e_async_busy", int'(busy), 0);
    check("e_async_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    wait_until(35);
    check("e_no_done", done_cyc_q.size(), 0);
    check("e_no_upd", upd_val_q.size(), 0);
    check("e_duty_idle", int'(duty), 0);
    check("e_busy_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
